// File: rtl/fpu_pkg.sv
// Shared definitions for the floating-point adder datapath stages.
package fpu_pkg;

    localparam int N_FLOAT = 32;
    localparam int N_EXP   = 8;
    localparam int N_MANT  = 23;

    localparam logic [N_EXP-1:0] EXP_MAX  = {N_EXP{1'b1}};
    localparam logic [N_EXP-1:0] EXP_BIAS = 8'd127;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } state_t;

endpackage

// File: rtl/rne_round.sv
// Round-to-nearest-even on a normalised significand (hidden bit + stored fraction).
module rne_round #(
    parameter int N_mant = 23
) (
    input  logic [N_mant:0]   sig,
    input  logic              guard,
    input  logic              round,
    input  logic              sticky,
    output logic [N_mant-1:0] frac,
    output logic              carry,
    output logic              inexact
);

    logic round_up;

    // An all-ones significand that rounds up wraps the fraction to zero, which is
    // exactly the renormalised 1.0 fraction, so only the carry needs reporting.
    always_comb begin
        round_up = guard & (round | sticky | sig[0]);
        frac     = sig[N_mant-1:0] + {{(N_mant-1){1'b0}}, round_up};
        carry    = (&sig) & round_up;
        inexact  = guard | round | sticky;
    end

endmodule

// File: rtl/fpu_norm_round.sv
// Normalise / round / pack stage: one normalising shift per cycle, RNE rounding,
// saturation to infinity and flush-to-zero, with a start/done handshake.
module fpu_norm_round
    import fpu_pkg::*;
#(
    parameter int N_float = N_FLOAT,
    parameter int N_exp   = N_EXP,
    parameter int N_mant  = N_MANT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_sign,
    input  logic [N_exp-1:0]   in_exp,
    input  logic [N_mant+3:0]  in_mant,
    input  logic               in_sticky,
    output logic               busy,
    output logic               done,
    output logic [N_float-1:0] result,
    output logic               overflow,
    output logic               underflow,
    output logic               inexact
);

    localparam int              W_M     = N_mant + 4;
    localparam logic [N_exp:0] EXP_TOP = {1'b0, {N_exp{1'b1}}};
    localparam logic [N_exp:0] EXP_ONE = {{N_exp{1'b0}}, 1'b1};

    state_t            state;
    logic              sign_r;
    logic [N_exp:0]    exp_r;
    logic [W_M-1:0]    mant_r;
    logic              sticky_r;

    logic [N_mant-1:0] r_frac;
    logic              r_carry;
    logic              r_inexact;
    logic [N_exp:0]    exp_final;

    rne_round #(.N_mant(N_mant)) u_round (
        .sig     (mant_r[W_M-2:2]),
        .guard   (mant_r[1]),
        .round   (mant_r[0]),
        .sticky  (sticky_r),
        .frac    (r_frac),
        .carry   (r_carry),
        .inexact (r_inexact)
    );

    assign exp_final = exp_r + {{N_exp{1'b0}}, r_carry};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sign_r    <= 1'b0;
            exp_r     <= '0;
            mant_r    <= '0;
            sticky_r  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_r    <= in_sign;
                        exp_r     <= {1'b0, in_exp};
                        mant_r    <= in_mant;
                        sticky_r  <= in_sticky;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        inexact   <= 1'b0;
                        busy      <= 1'b1;
                        state     <= NORM;
                    end
                end
                NORM: begin
                    if (mant_r[W_M-1]) begin
                        mant_r   <= mant_r >> 1;
                        exp_r    <= exp_r + EXP_ONE;
                        sticky_r <= sticky_r | mant_r[0];
                        state    <= ROUND;
                    end else if (mant_r[W_M-2]) begin
                        state <= ROUND;
                    end else if (mant_r == '0 && !sticky_r) begin
                        result <= '0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (exp_r <= EXP_ONE) begin
                        // Denormals are never produced: running out of exponent flushes to zero.
                        result    <= {sign_r, {(N_float-1){1'b0}}};
                        underflow <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        mant_r <= mant_r << 1;
                        exp_r  <= exp_r - EXP_ONE;
                    end
                end
                ROUND: begin
                    inexact <= r_inexact;
                    if (exp_final >= EXP_TOP) begin
                        result   <= {sign_r, {N_exp{1'b1}}, {N_mant{1'b0}}};
                        overflow <= 1'b1;
                    end else begin
                        result <= {sign_r, exp_final[N_exp-1:0], r_frac};
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_norm_round.sv
// Scoreboard bench for fpu_norm_round: stimulus pushes model predictions, a monitor checks each done.
module tb_fpu_norm_round;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [26:0] in_mant;
    logic        in_sticky;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        inexact;

    typedef struct {
        logic [31:0] result;
        logic        ovf;
        logic        unf;
        logic        inx;
        int          lat;
        int          start_cyc;
    } expect_t;

    expect_t sb[$];
    int      cyc      = 0;
    int      n_tests  = 0;
    int      n_fail   = 0;
    int      n_issued = 0;
    int      n_done   = 0;

    fpu_norm_round dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .in_sticky (in_sticky),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .inexact   (inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: value-level normalisation count, then RNE on the 24-bit significand.
    function automatic expect_t model(input bit s, input int e, input logic [26:0] m, input bit st);
        expect_t x;
        int      p;
        int      k;
        int      q;
        int      sig;
        bit      g;
        bit      r;
        bit      stk;
        bit      ru;
        logic [26:0] mn;
        x.result = 32'h0;
        x.ovf = 1'b0;
        x.unf = 1'b0;
        x.inx = 1'b0;
        x.start_cyc = 0;
        if (m == 27'h0 && !st) begin
            x.lat = 2;
            return x;
        end
        if (m[26]) begin
            e   = e + 1;
            sig = int'(m[26:3]);
            g   = m[2];
            r   = m[1];
            stk = st | m[0];
            x.lat = 3;
        end else begin
            p = -1;
            for (int i = 0; i < 26; i++) if (m[i]) p = i;
            k = (p < 0) ? 1000 : 25 - p;
            if (k > e - 1) begin
                x.result = {s, 31'h0};
                x.unf = 1'b1;
                x.lat = e + 1;
                return x;
            end
            mn  = m << k;
            e   = e - k;
            sig = int'(mn[25:2]);
            g   = mn[1];
            r   = mn[0];
            stk = st;
            x.lat = 3 + k;
        end
        ru = g & (r | stk | sig[0]);
        q  = sig + int'(ru);
        if (q == (1 << 24)) begin
            q = 1 << 23;
            e = e + 1;
        end
        x.inx = g | r | stk;
        if (e >= 255) begin
            x.result = {s, 8'hFF, 23'h0};
            x.ovf = 1'b1;
        end else begin
            x.result = {s, 8'(e), 23'(q)};
        end
        return x;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding prediction.
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            if (sb.size() == 0) begin
                check_output("unexpected_done", 64'(result), 64'hDEAD);
            end else begin
                expect_t x;
                x = sb.pop_front();
                check_output("result", 64'(result), 64'(x.result));
                check_output("flags", 64'({overflow, underflow, inexact}), 64'({x.ovf, x.unf, x.inx}));
                check_output("latency", 64'(cyc - x.start_cyc), 64'(x.lat));
                check_output("busy_at_done", 64'(busy), 64'h0);
            end
        end
    end

    task automatic apply_stimulus(input bit s, input logic [7:0] e, input logic [26:0] m,
                                  input bit st, input bit poke);
        expect_t x;
        bit      seen;
        @(posedge clk);
        #1;
        in_sign   = s;
        in_exp    = e;
        in_mant   = m;
        in_sticky = st;
        start     = 1'b1;
        x = model(s, int'(e), m, st);
        x.start_cyc = cyc;
        sb.push_back(x);
        n_issued++;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (poke) begin
            in_mant = 27'h4000000;
            in_exp  = 8'h10;
            start   = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            check_output("done_timeout", 64'h0, 64'h1);
            sb.delete();
        end else if (poke) begin
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        @(posedge clk);
    endtask

    initial begin
        logic [26:0] m;
        int          e;
        int          cat;
        rst       = 1'b1;
        start     = 1'b0;
        in_sign   = 1'b0;
        in_exp    = 8'h0;
        in_mant   = 27'h0;
        in_sticky = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("reset_state", 64'({busy, done, result, overflow, underflow, inexact}), 64'h0);

        apply_stimulus(1'b0, 8'h7F, 27'h2000000, 1'b0, 1'b0);
        apply_stimulus(1'b0, 8'h7F, 27'h4000000, 1'b0, 1'b0);
        apply_stimulus(1'b0, 8'h7F, 27'h1000000, 1'b0, 1'b0);
        apply_stimulus(1'b0, 8'h7F, 27'h3FFFFFE, 1'b0, 1'b0);
        apply_stimulus(1'b0, 8'h7F, 27'h2000002, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'h7F, 27'h0000000, 1'b0, 1'b0);
        apply_stimulus(1'b0, 8'hFE, 27'h4000000, 1'b0, 1'b0);
        apply_stimulus(1'b0, 8'h01, 27'h1000000, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'h05, 27'h0000000, 1'b1, 1'b0);
        apply_stimulus(1'b1, 8'hFE, 27'h3FFFFFE, 1'b1, 1'b0);
        apply_stimulus(1'b0, 8'h40, 27'h0000100, 1'b1, 1'b1);

        // Abort a long normalisation with reset: no done may follow.
        @(posedge clk);
        #1;
        in_exp  = 8'h7F;
        in_mant = 27'h0000001;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("reset_abort", 64'({busy, done, result, overflow, underflow, inexact}), 64'h0);
        repeat (40) @(posedge clk);

        for (int t = 0; t < 150; t++) begin
            cat = int'($urandom_range(0, 9));
            m   = 27'($urandom);
            if (cat < 3)      m[26] = 1'b1;
            else if (cat < 6) m = {2'b01, m[24:0]};
            else if (cat < 9) m = {1'b0, m[25:0]} >> $urandom_range(1, 25);
            else              m = 27'h0;
            if ($urandom_range(0, 3) == 0)      e = int'($urandom_range(1, 30));
            else if ($urandom_range(0, 2) == 0) e = int'($urandom_range(240, 254));
            else                                 e = int'($urandom_range(1, 254));
            apply_stimulus(1'($urandom), 8'(e), m, 1'($urandom), 1'b0);
        end

        repeat (5) @(posedge clk);
        check_output("done_count", 64'(n_done), 64'(n_issued));
        check_output("scoreboard_empty", 64'(sb.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
